systime_counter: RTL and testbench

//  Free-running 64-bit system time base. Its count drives time_in of the system command block and its low word drives systime.

---
 rtl/systime_counter_pkg.sv | 20 ++
 rtl/systime_sync_gen.sv | 60 ++++++
 rtl/systime_counter.sv | 69 ++++++
 tb/tb_systime_counter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/systime_counter_pkg.sv
// Shared widths and helpers for the system time base.
//   SYSTIME_W : width of the free-running time count
//   DRIFT_W   : width of the signed drift trim and of the phase accumulator
//   drift_inc : per-cycle increment (0, 1 or 2) from the trim sign and accumulator carry
package systime_counter_pkg;

  localparam int SYSTIME_W = 64;
  localparam int DRIFT_W   = 32;

  // inc = 1 + c. A positive trim adds a count on carry-out. A negative trim
  // (added as its unsigned two's-complement image) drops a count when the
  // add does NOT carry, because that is a borrow.
  function automatic logic [1:0] drift_inc(input logic neg, input logic carry);
    logic [1:0] inc;
    if (neg) inc = carry ? 2'd1 : 2'd0;
    else     inc = carry ? 2'd2 : 2'd1;
    return inc;
  endfunction

endpackage

// File: rtl/systime_sync_gen.sv
// Master-mode timesync strobe generator.
//   clk, rst   : system clock, asynchronous active-high reset
//   master_en  : 1 = period counter runs and strobes are generated
//   pulse_out  : toggles each time the period counter wraps
//   latch_out  : high for LATCH_LEN cycles starting LATCH_DELAY cycles after a toggle
// Counter, pulse and latch are all flops. Timing depends only on clk cycles,
// never on the time value.
module systime_sync_gen #(
  parameter int SYNC_PERIOD = 1000000,
  parameter int LATCH_DELAY = 16,
  parameter int LATCH_LEN   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic master_en,
  output logic pulse_out,
  output logic latch_out
);

  localparam int CNT_W = (SYNC_PERIOD > 2) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);
  localparam logic [CNT_W-1:0] LAT_LO   = CNT_W'(LATCH_DELAY);
  localparam logic [CNT_W-1:0] LAT_HI   = CNT_W'(LATCH_DELAY + LATCH_LEN - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             armed;
  logic             armed_next;
  logic             wrap;

  // armed marks that at least one toggle has happened since counting
  // (re)started. Before the first toggle there is nothing for the latch
  // strobe to follow, so it stays low.
  always_comb begin
    wrap       = (cnt == CNT_LAST);
    cnt_next   = wrap ? '0 : cnt + 1'b1;
    armed_next = armed | wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      armed     <= 1'b0;
      pulse_out <= 1'b0;
      latch_out <= 1'b0;
    end else if (!master_en) begin
      // Leaving master mode: restart the period, drop latch, hold pulse level.
      cnt       <= '0;
      armed     <= 1'b0;
      latch_out <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      armed     <= armed_next;
      if (wrap) pulse_out <= ~pulse_out;
      // latch_out registered against the count it will sit beside.
      latch_out <= armed_next && (cnt_next >= LAT_LO) && (cnt_next <= LAT_HI);
    end
  end

endmodule

// File: rtl/systime_counter.sv
// Free-running 64-bit system time base with drift trim and load.
//   clk, rst           : system clock, asynchronous active-high reset
//   time_load          : value loaded into the count (system.time_out)
//   time_load_en       : one-cycle load strobe; load beats increment
//   drift_rate         : signed trim in 2^-32 counts per cycle
//   master_en          : enables the timesync strobe generator
//   time_now           : current time (system.time_in), registered
//   systime            : low word of time_now
//   timesync_pulse_out : toggles once per SYNC_PERIOD in master mode
//   timesync_latch_out : LATCH_LEN-cycle strobe, LATCH_DELAY after each toggle
// Load latency is exactly one cycle; the downstream block relies on that.
module systime_counter
  import systime_counter_pkg::*;
#(
  parameter int SYNC_PERIOD = 1000000,
  parameter int LATCH_DELAY = 16,
  parameter int LATCH_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SYSTIME_W-1:0] time_load,
  input  logic                 time_load_en,
  input  logic [DRIFT_W-1:0]   drift_rate,
  input  logic                 master_en,
  output logic [SYSTIME_W-1:0] time_now,
  output logic [31:0]          systime,
  output logic                 timesync_pulse_out,
  output logic                 timesync_latch_out
);

  logic [DRIFT_W-1:0]   acc;
  logic [DRIFT_W:0]     acc_sum;
  logic [1:0]           inc;
  logic [SYSTIME_W-1:0] time_next;

  // The phase accumulator keeps running through loads so trim phase is
  // never lost when software re-syncs the time value.
  always_comb begin
    acc_sum   = {1'b0, acc} + {1'b0, drift_rate};
    inc       = drift_inc(drift_rate[DRIFT_W-1], acc_sum[DRIFT_W]);
    time_next = time_load_en ? time_load
                             : time_now + {{(SYSTIME_W-2){1'b0}}, inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      time_now <= '0;
    end else begin
      acc      <= acc_sum[DRIFT_W-1:0];
      time_now <= time_next;
    end
  end

  assign systime = time_now[31:0];

  systime_sync_gen #(
    .SYNC_PERIOD (SYNC_PERIOD),
    .LATCH_DELAY (LATCH_DELAY),
    .LATCH_LEN   (LATCH_LEN)
  ) u_sync_gen (
    .clk       (clk),
    .rst       (rst),
    .master_en (master_en),
    .pulse_out (timesync_pulse_out),
    .latch_out (timesync_latch_out)
  );

endmodule

// File: tb/tb_systime_counter.sv
module tb_systime_counter;

  localparam int P = 20;
  localparam int D = 4;
  localparam int L = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] time_load;
  logic        time_load_en;
  logic [31:0] drift_rate;
  logic        master_en;
  logic [63:0] time_now;
  logic [31:0] systime;
  logic        timesync_pulse_out;
  logic        timesync_latch_out;

  always #5 clk = ~clk;

  systime_counter #(
    .SYNC_PERIOD (P),
    .LATCH_DELAY (D),
    .LATCH_LEN   (L)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .time_load          (time_load),
    .time_load_en       (time_load_en),
    .drift_rate         (drift_rate),
    .master_en          (master_en),
    .time_now           (time_now),
    .systime            (systime),
    .timesync_pulse_out (timesync_pulse_out),
    .timesync_latch_out (timesync_latch_out)
  );

  // ---------------- reference model ----------------
  // Time and trim phase as one 96-bit fixed-point value (32 fraction bits):
  // each cycle it gains 1.0 plus the sign-extended trim.
  logic [95:0] fx;
  int          k;        // cycles counted since master mode (re)started
  logic        m_pulse;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic exp_latch();
    return (k >= P) && ((k % P) >= D) && ((k % P) <= D + L - 1);
  endfunction

  task automatic model_reset();
    fx = '0; k = 0; m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] frac;
    frac = fx[31:0] + drift_rate;
    if (time_load_en) fx = {time_load, frac};
    else fx = fx + {32'd0, 32'd1, 32'd0} + {{64{drift_rate[31]}}, drift_rate};
    if (master_en) begin
      k++;
      if (k % P == 0) m_pulse = ~m_pulse;
    end else begin
      k = 0;
    end
  endtask

  task automatic compare_all();
    chk("time_now", time_now, fx[95:32]);
    chk("systime", {32'd0, systime}, {32'd0, fx[63:32]});
    chk("pulse", {63'd0, timesync_pulse_out}, {63'd0, m_pulse});
    chk("latch", {63'd0, timesync_latch_out}, {63'd0, exp_latch()});
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the negedge; one step = one active edge then a check.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- table-driven drift vectors ----------------
  typedef struct {
    logic [31:0] drift;
    int          cycles;
    logic [63:0] exp_time;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst = 1'b1; time_load = '0; time_load_en = 1'b0; drift_rate = '0; master_en = 1'b0;
    model_reset();

    // Reset state, checked while rst is still held.
    #2;
    chk("rst_time", time_now, 64'd0);
    chk("rst_systime", {32'd0, systime}, 64'd0);
    chk("rst_pulse", {63'd0, timesync_pulse_out}, 64'd0);
    chk("rst_latch", {63'd0, timesync_latch_out}, 64'd0);

    // Each row starts from reset (time 0, phase 0).
    vecs[0] = '{32'h0000_0000, 10, 64'd10};
    vecs[1] = '{32'h8000_0000, 100, 64'd50};   // -0.5 counts/cycle
    vecs[2] = '{32'hC000_0000, 100, 64'd75};   // -0.25
    vecs[3] = '{32'h4000_0000, 100, 64'd125};  // +0.25
    vecs[4] = '{32'h0000_0001, 100, 64'd100};  // tiny positive, no carry yet
    vecs[5] = '{32'hFFFF_FFFF, 100, 64'd99};   // tiny negative, one borrow
    foreach (vecs[i]) begin
      do_reset();
      drift_rate = vecs[i].drift;
      repeat (vecs[i].cycles) step();
      chk($sformatf("drift_row%0d", i), time_now, vecs[i].exp_time);
      chk($sformatf("drift_row%0d_sys", i), {32'd0, systime}, {32'd0, vecs[i].exp_time[31:0]});
    end
    chk("idle_pulse", {63'd0, timesync_pulse_out}, 64'd0);
    chk("idle_latch", {63'd0, timesync_latch_out}, 64'd0);

    // Load then carry across the word boundary.
    drift_rate = '0;
    time_load = 64'h0000_0001_FFFF_FFFE; time_load_en = 1'b1;
    step();
    chk("load_exact", time_now, 64'h0000_0001_FFFF_FFFE);
    time_load_en = 1'b0;
    step();
    chk("load_plus1", time_now, 64'h0000_0001_FFFF_FFFF);
    step();
    chk("word_carry", time_now, 64'h0000_0002_0000_0000);
    chk("word_carry_sys", {32'd0, systime}, 64'd0);

    // 64-bit wrap.
    time_load = 64'hFFFF_FFFF_FFFF_FFFF; time_load_en = 1'b1;
    step();
    chk("load_all_ones", time_now, 64'hFFFF_FFFF_FFFF_FFFF);
    time_load_en = 1'b0;
    step();
    chk("wrap_to_zero", time_now, 64'd0);

    // Load on the edge where a carry would happen, then back-to-back loads.
    time_load = 64'h0000_0000_FFFF_FFFF; time_load_en = 1'b1;
    step();
    time_load = 64'h0000_0000_0000_0055;
    step();
    chk("load_beats_carry", time_now, 64'h55);
    time_load = 64'hAAAA_0000_1234_5678;
    step();
    time_load = 64'h1111_2222_3333_4444;
    step();
    chk("b2b_last_wins", time_now, 64'h1111_2222_3333_4444);
    time_load_en = 1'b0;
    step();
    chk("b2b_then_count", time_now, 64'h1111_2222_3333_4445);

    // Sync generator from reset.
    do_reset();
    master_en = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 19) chk("pulse_before", {63'd0, timesync_pulse_out}, 64'd0);
      if (c == 20) chk("pulse_toggle", {63'd0, timesync_pulse_out}, 64'd1);
      if (c == 23) chk("latch_pre", {63'd0, timesync_latch_out}, 64'd0);
      if (c == 24) chk("latch_start", {63'd0, timesync_latch_out}, 64'd1);
    end
    // Count 5 after toggle: mid-latch. Drop master mode.
    master_en = 1'b0;
    step();
    chk("drop_latch", {63'd0, timesync_latch_out}, 64'd0);
    chk("drop_pulse_held", {63'd0, timesync_pulse_out}, 64'd1);
    repeat (3) step();
    master_en = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      step();
      if (c == 19) chk("reen_pulse_before", {63'd0, timesync_pulse_out}, 64'd1);
      if (c == 20) chk("reen_pulse_toggle", {63'd0, timesync_pulse_out}, 64'd0);
      if (c == 26) chk("reen_latch", {63'd0, timesync_latch_out}, 64'd1);
      if (c == 27) chk("reen_latch_end", {63'd0, timesync_latch_out}, 64'd0);
    end

    // Asynchronous reset between edges, mid-count and mid-latch.
    do_reset();
    master_en = 1'b1; drift_rate = 32'h4000_0000;
    repeat (25) step();
    chk("pre_async_latch", {63'd0, timesync_latch_out}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_time", time_now, 64'd0);
    chk("async_systime", {32'd0, systime}, 64'd0);
    chk("async_pulse", {63'd0, timesync_pulse_out}, 64'd0);
    chk("async_latch", {63'd0, timesync_latch_out}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drift_rate = '0;
    step();
    chk("restart_count", time_now, 64'd1);
    repeat (19) step();
    chk("restart_full_period", {63'd0, timesync_pulse_out}, 64'd1);

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) drift_rate = $urandom();
      else if ($urandom_range(0, 199) == 0) drift_rate = '0;
      time_load_en = ($urandom_range(0, 19) == 0);
      time_load    = {$urandom(), $urandom()};
      if ($urandom_range(0, 59) == 0) master_en = ~master_en;
      step();
    end
    time_load_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
